lc3_imem_ctrl: RTL and testbench



---
 rtl/lc3_imem_ctrl.sv | 63 ++++++
 tb/tb_lc3_imem_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lc3_imem_ctrl.sv
// lc3_imem_ctrl: LC3 instruction-memory controller with fixed wait states and a preload port.
module lc3_imem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       PC,
    input  logic              instrmem_rd,
    output logic [15:0]       instr_dout,
    output logic              complete_instr,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    output logic              busy,
    output logic              oob_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] W4 = 4'(WAIT_STATES);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] req_pc_q, req_pc_d, dout_q, dout_d, rd_pc;
    logic        complete_q, complete_d, oob_q, oob_d, req, resp_go, oob;
    logic [15:0] mem [2**ADDR_W];
    always_comb begin
        req        = state_q == IDLE && instrmem_rd;
        // With no wait states the array is read straight from PC in the accepting cycle
        rd_pc      = state_q == IDLE ? PC : req_pc_q;
        oob        = (rd_pc >> ADDR_W) != 16'd0;
        resp_go    = (req && W4 == 4'd0) || (state_q == WAIT && cnt_q == 4'd1);
        state_d    = resp_go ? RESP : req ? WAIT : state_q == RESP ? IDLE : state_q;
        cnt_d      = req ? W4 : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        req_pc_d   = req ? PC : req_pc_q;
        dout_d     = resp_go ? (oob ? 16'h0000 : mem[rd_pc[ADDR_W-1:0]]) : dout_q;
        complete_d = resp_go;
        oob_d      = resp_go && oob;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            req_pc_q   <= 16'd0;
            dout_q     <= 16'd0;
            complete_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_pc_q   <= req_pc_d;
            dout_q     <= dout_d;
            complete_q <= complete_d;
            oob_q      <= oob_d;
        end
    end
    // Array is never reset; writes land even during reset
    always_ff @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
    end
    assign instr_dout     = dout_q;
    assign complete_instr = complete_q;
    assign oob_err        = oob_q;
    assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_lc3_imem_ctrl.sv
// tb_lc3_imem_ctrl: directed checks of the imem controller with 2 and 0 wait states.
module tb_lc3_imem_ctrl;
    logic        clk = 1'b0, reset = 1'b0, rd2 = 1'b0, rd0 = 1'b0, load_en = 1'b0;
    logic [15:0] pc = 16'd0, load_data = 16'd0;
    logic [7:0]  load_addr = 8'd0;
    logic [15:0] dout2, dout0;
    logic        cmp2, cmp0, busy2, busy0, oob2, oob0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    lc3_imem_ctrl #(.ADDR_W(8), .WAIT_STATES(2)) d2 (
        .clock(clk), .reset(reset), .PC(pc), .instrmem_rd(rd2), .instr_dout(dout2),
        .complete_instr(cmp2), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .busy(busy2), .oob_err(oob2));

    lc3_imem_ctrl #(.ADDR_W(8), .WAIT_STATES(0)) d0 (
        .clock(clk), .reset(reset), .PC(pc), .instrmem_rd(rd0), .instr_dout(dout0),
        .complete_instr(cmp0), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .busy(busy0), .oob_err(oob0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pc = 16'($urandom); rd2 = 1'($urandom); rd0 = 1'($urandom);
            step();
        end
        reset = 1'b0; rd2 = 1'b0; rd0 = 1'b0;
        checks++; if (dout2 !== 16'h0000) begin errors++; $display("FAIL reset_dout2 got %h want 0000", dout2); end
        checks++; if ({cmp2, busy2, oob2} !== 3'b000) begin errors++; $display("FAIL reset_flags2 got %b want 000", {cmp2, busy2, oob2}); end
        checks++; if (dout0 !== 16'h0000) begin errors++; $display("FAIL reset_dout0 got %h want 0000", dout0); end
        checks++; if ({cmp0, busy0, oob0} !== 3'b000) begin errors++; $display("FAIL reset_flags0 got %b want 000", {cmp0, busy0, oob0}); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({cmp2, cmp0} !== 2'b00) begin errors++; $display("FAIL reset_idle_cmp got %b want 00", {cmp2, cmp0}); end
        end
    endtask

    task automatic test_basic_fetch();
        pc = 16'd5; rd2 = 1'b1;
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL basic_busy_c0 got %b want 0", busy2); end
        step();
        rd2 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (busy2 !== (c <= 3)) begin errors++; $display("FAIL basic_busy_c%0d got %b want %b", c, busy2, c <= 3); end
            checks++; if (cmp2 !== (c == 3)) begin errors++; $display("FAIL basic_cmp_c%0d got %b want %b", c, cmp2, c == 3); end
            if (c >= 3) begin
                checks++; if (dout2 !== 16'h1234) begin errors++; $display("FAIL basic_dout_c%0d got %h want 1234", c, dout2); end
            end
            step();
        end
    endtask

    task automatic test_out_of_range();
        pc = 16'h3000; rd2 = 1'b1;
        step();
        rd2 = 1'b0;
        step(); step();
        checks++; if ({cmp2, oob2} !== 2'b11) begin errors++; $display("FAIL oob_flags got %b want 11", {cmp2, oob2}); end
        checks++; if (dout2 !== 16'h0000) begin errors++; $display("FAIL oob_dout got %h want 0000", dout2); end
        step();
        checks++; if ({cmp2, oob2} !== 2'b00) begin errors++; $display("FAIL oob_after got %b want 00", {cmp2, oob2}); end
        pc = 16'h0100; rd0 = 1'b1;
        step();
        rd0 = 1'b0;
        checks++; if ({cmp0, oob0, dout0} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL oob_w0 got %b%b %h want 11 0000", cmp0, oob0, dout0); end
        step();
    endtask

    task automatic test_pc_change();
        pc = 16'd5; rd2 = 1'b1;
        step();
        pc = 16'd6;
        step(); step();
        rd2 = 1'b0;
        checks++; if ({cmp2, dout2} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL pc_change got %b %h want 1 1234", cmp2, dout2); end
        step();
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL pc_change_idle got %b want 0", busy2); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        pc = 16'd5;
        for (int i = 0; i < 6; i++) begin
            rd0 = 1'b1;
            checks++; if (cmp0 !== 1'(i % 2)) begin errors++; $display("FAIL b2b_cmp_c%0d got %b want %b", i, cmp0, 1'(i % 2)); end
            if (cmp0 === 1'b1) begin
                n++;
                checks++; if (dout0 !== 16'h1234) begin errors++; $display("FAIL b2b_dout_c%0d got %h want 1234", i, dout0); end
            end
            step();
        end
        rd0 = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", n); end
        checks++; if (cmp0 !== 1'b0) begin errors++; $display("FAIL b2b_after got %b want 0", cmp0); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        pc = 16'd5; rd2 = 1'b1;
        step();
        rd2 = 1'b0; reset = 1'b1;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy2); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({cmp2, busy2, oob2} !== 3'b000) begin errors++; $display("FAIL abort_c%0d got %b want 000", i, {cmp2, busy2, oob2}); end
            step();
        end
    endtask

    task automatic test_collision();
        pc = 16'd5; rd2 = 1'b1;
        step();
        rd2 = 1'b0;
        step();
        load_en = 1'b1; load_addr = 8'd5; load_data = 16'hBEEF;
        step();
        load_en = 1'b0;
        checks++; if ({cmp2, dout2} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL collide_old got %b %h want 1 1234", cmp2, dout2); end
        step();
        rd2 = 1'b1;
        step();
        rd2 = 1'b0;
        step(); step();
        checks++; if ({cmp2, dout2} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL collide_new got %b %h want 1 beef", cmp2, dout2); end
        step();
    endtask

    initial begin
        step();
        test_reset();
        load(8'd5, 16'h1234);
        load(8'd6, 16'h5678);
        test_basic_fetch();
        test_out_of_range();
        test_pc_change();
        test_back_to_back();
        test_reset_mid_wait();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
